vec_bitwise_sequencer: RTL and testbench

Sequencer that executes one vector bitwise instruction (AND/OR/XOR) element by element. It walks the source operand vectors through a synchronous-read element register file and presents each element pair to the combinational bitwise operation unit. It writes each result back to the destination vector at one element per cycle. It sits between the vector instruction decoder (command side) and the bitwise operation unit / register file (datapath side).

---
 rtl/vec_bitwise_sequencer.sv | 232 +++++++++++++++++++++++
 tb/tb_vec_bitwise_sequencer.sv | 505 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_bitwise_sequencer.sv
// ---------------------------------------------------------------------------
// vec_bitwise_sequencer
//
// Runs one vector bitwise instruction (AND / OR / XOR / zero) one element per
// cycle. It reads both source vectors from a synchronous-read element register
// file, sends each element pair to a combinational bitwise unit, and writes
// the registered result back to the destination vector.
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both 1. cmd_ready is 1 only while idle. cmd_valid held
// during a command is ignored until the sequencer is idle again.
//
// Ports
//   clk, reset_n                 clock, synchronous active-low reset
//   cmd_valid / cmd_ready        command handshake
//   cmd_op                       00 AND, 01 OR, 10 XOR, 11 zero
//   cmd_src_a/_b, cmd_dst        base element addresses
//   cmd_vl                       element count, 0..2^ADDR_W
//   rd_en, rd_addr_a/_b          register-file read port (data one cycle later)
//   rd_data_a/_b                 register-file read data
//   bw_operand_a/_b, bw_control  to the bitwise unit
//   bw_result                    combinational result from the bitwise unit
//   wr_en, wr_addr, wr_data      register-file write port
//   busy                         command in flight
//   done                         one-cycle pulse with the final write
// ---------------------------------------------------------------------------
module vec_bitwise_sequencer #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int VL_W   = 6
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_src_a,
   input  logic [ADDR_W-1:0] cmd_src_b,
   input  logic [ADDR_W-1:0] cmd_dst,
   input  logic [VL_W-1:0]   cmd_vl,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr_a,
   output logic [ADDR_W-1:0] rd_addr_b,
   input  logic [DATA_W-1:0] rd_data_a,
   input  logic [DATA_W-1:0] rd_data_b,
   output logic [DATA_W-1:0] bw_operand_a,
   output logic [DATA_W-1:0] bw_operand_b,
   output logic [1:0]        bw_control,
   input  logic [DATA_W-1:0] bw_result,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t              state_q,     state_d;
   logic [1:0]          op_q,        op_d;
   logic [ADDR_W-1:0]   src_a_q,     src_a_d;
   logic [ADDR_W-1:0]   src_b_q,     src_b_d;
   logic [ADDR_W-1:0]   dst_q,       dst_d;
   logic [VL_W-1:0]     vl_q,        vl_d;
   logic [VL_W-1:0]     i_q,         i_d;        // elements issued so far
   logic                rd_en_q,     rd_en_d;
   logic [ADDR_W-1:0]   rd_addr_a_q, rd_addr_a_d;
   logic [ADDR_W-1:0]   rd_addr_b_q, rd_addr_b_d;
   logic [ADDR_W-1:0]   rd_idx_q,    rd_idx_d;   // element index of the read in flight
   logic                s2_valid_q,  s2_valid_d; // read data present this cycle
   logic [ADDR_W-1:0]   s2_idx_q,    s2_idx_d;
   logic [DATA_W-1:0]   opnd_a_q,    opnd_a_d;   // last operands, held while idle
   logic [DATA_W-1:0]   opnd_b_q,    opnd_b_d;
   logic [1:0]          ctrl_q,      ctrl_d;
   logic                wr_en_q,     wr_en_d;
   logic [ADDR_W-1:0]   wr_addr_q,   wr_addr_d;
   logic [DATA_W-1:0]   wr_data_q,   wr_data_d;
   logic                busy_q,      busy_d;
   logic                done_q,      done_d;
   logic                cmd_ready_q, cmd_ready_d;

   // The read data goes straight to the unit in the cycle it arrives.
   // Otherwise the last pair is held so the unit inputs stay quiet.
   assign bw_operand_a = s2_valid_q ? rd_data_a : opnd_a_q;
   assign bw_operand_b = s2_valid_q ? rd_data_b : opnd_b_q;
   assign bw_control   = s2_valid_q ? op_q      : ctrl_q;

   assign cmd_ready = cmd_ready_q;
   assign rd_en     = rd_en_q;
   assign rd_addr_a = rd_addr_a_q;
   assign rd_addr_b = rd_addr_b_q;
   assign wr_en     = wr_en_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign busy      = busy_q;
   assign done      = done_q;

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      src_a_d     = src_a_q;
      src_b_d     = src_b_q;
      dst_d       = dst_q;
      vl_d        = vl_q;
      i_d         = i_q;
      rd_en_d     = 1'b0;
      rd_addr_a_d = rd_addr_a_q;
      rd_addr_b_d = rd_addr_b_q;
      rd_idx_d    = rd_idx_q;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;

      // Read-data stage and write stage follow the read strobe by one and
      // two cycles, independent of the FSM state.
      s2_valid_d  = rd_en_q;
      s2_idx_d    = rd_idx_q;
      opnd_a_d    = bw_operand_a;
      opnd_b_d    = bw_operand_b;
      ctrl_d      = bw_control;
      wr_en_d     = s2_valid_q;
      if (s2_valid_q) begin
         wr_addr_d = dst_q + s2_idx_q;
         wr_data_d = bw_result;
      end

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               op_d    = cmd_op;
               src_a_d = cmd_src_a;
               src_b_d = cmd_src_b;
               dst_d   = cmd_dst;
               vl_d    = cmd_vl;
               i_d     = '0;
               if (cmd_vl == '0) begin
                  state_d = ST_DRAIN;
               end else begin
                  // Element 0 is issued straight from the accept edge so the
                  // first read strobe appears in the cycle after the handshake.
                  state_d     = ST_RUN;
                  rd_en_d     = 1'b1;
                  rd_addr_a_d = cmd_src_a;
                  rd_addr_b_d = cmd_src_b;
                  rd_idx_d    = '0;
                  i_d         = VL_W'(1);
               end
            end
         end
         ST_RUN: begin
            if (i_q == vl_q) begin
               state_d = ST_DRAIN;
            end else begin
               rd_en_d     = 1'b1;
               rd_addr_a_d = src_a_q + i_q[ADDR_W-1:0];
               rd_addr_b_d = src_b_q + i_q[ADDR_W-1:0];
               rd_idx_d    = i_q[ADDR_W-1:0];
               i_d         = i_q + VL_W'(1);
            end
         end
         ST_DRAIN: begin
            // done is high in the cycle of the final write; leave afterwards.
            if (done_q) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Once the read-data stage is empty in DRAIN, at most the final write
      // is left, and it happens in the same cycle as done.
      done_d      = (state_d == ST_DRAIN) && !s2_valid_d;
      busy_d      = (state_d != ST_IDLE);
      cmd_ready_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         op_q        <= '0;
         src_a_q     <= '0;
         src_b_q     <= '0;
         dst_q       <= '0;
         vl_q        <= '0;
         i_q         <= '0;
         rd_en_q     <= 1'b0;
         rd_addr_a_q <= '0;
         rd_addr_b_q <= '0;
         rd_idx_q    <= '0;
         s2_valid_q  <= 1'b0;
         s2_idx_q    <= '0;
         opnd_a_q    <= '0;
         opnd_b_q    <= '0;
         ctrl_q      <= '0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         cmd_ready_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         src_a_q     <= src_a_d;
         src_b_q     <= src_b_d;
         dst_q       <= dst_d;
         vl_q        <= vl_d;
         i_q         <= i_d;
         rd_en_q     <= rd_en_d;
         rd_addr_a_q <= rd_addr_a_d;
         rd_addr_b_q <= rd_addr_b_d;
         rd_idx_q    <= rd_idx_d;
         s2_valid_q  <= s2_valid_d;
         s2_idx_q    <= s2_idx_d;
         opnd_a_q    <= opnd_a_d;
         opnd_b_q    <= opnd_b_d;
         ctrl_q      <= ctrl_d;
         wr_en_q     <= wr_en_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         cmd_ready_q <= cmd_ready_d;
      end
   end

endmodule

// File: tb/tb_vec_bitwise_sequencer.sv
// ---------------------------------------------------------------------------
// tb_vec_bitwise_sequencer
//
// Directed bench for vec_bitwise_sequencer. The bench models a synchronous-read
// element register file with preload and a combinational bitwise unit.
// Each scenario task samples the outputs 1 time unit after every rising edge.
// It compares them against hand-computed values at exact cycle offsets from
// the command handshake edge c0.
// ---------------------------------------------------------------------------
module tb_vec_bitwise_sequencer;

   logic        clk;
   logic        reset_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [4:0]  cmd_src_a;
   logic [4:0]  cmd_src_b;
   logic [4:0]  cmd_dst;
   logic [5:0]  cmd_vl;
   logic        rd_en;
   logic [4:0]  rd_addr_a;
   logic [4:0]  rd_addr_b;
   logic [31:0] rd_data_a;
   logic [31:0] rd_data_b;
   logic [31:0] bw_operand_a;
   logic [31:0] bw_operand_b;
   logic [1:0]  bw_control;
   logic [31:0] bw_result;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic        busy;
   logic        done;

   int checks;
   int failures;

   // register-file model with a bench-side preload port
   logic [31:0] mem [32];
   logic        pl_en;
   logic [4:0]  pl_addr;
   logic [31:0] pl_data;

   vec_bitwise_sequencer #(.DATA_W(32), .ADDR_W(5), .VL_W(6)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_op       (cmd_op),
      .cmd_src_a    (cmd_src_a),
      .cmd_src_b    (cmd_src_b),
      .cmd_dst      (cmd_dst),
      .cmd_vl       (cmd_vl),
      .rd_en        (rd_en),
      .rd_addr_a    (rd_addr_a),
      .rd_addr_b    (rd_addr_b),
      .rd_data_a    (rd_data_a),
      .rd_data_b    (rd_data_b),
      .bw_operand_a (bw_operand_a),
      .bw_operand_b (bw_operand_b),
      .bw_control   (bw_control),
      .bw_result    (bw_result),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .busy         (busy),
      .done         (done)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- register file and bitwise unit models ----------------
   always @(posedge clk) begin
      if (rd_en) begin
         rd_data_a <= mem[rd_addr_a];
         rd_data_b <= mem[rd_addr_b];
      end
      if (wr_en) mem[wr_addr] = wr_data;
      if (pl_en) mem[pl_addr] = pl_data;
   end

   always_comb begin
      case (bw_control)
         2'b00:   bw_result = bw_operand_a & bw_operand_b;
         2'b01:   bw_result = bw_operand_a | bw_operand_b;
         2'b10:   bw_result = bw_operand_a ^ bw_operand_b;
         default: bw_result = 32'h0000_0000;
      endcase
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [4:0] a, input logic [31:0] d);
      pl_en   = 1'b1;
      pl_addr = a;
      pl_data = d;
      tick();
      pl_en   = 1'b0;
   endtask

   // Presents one command for exactly one edge (c0); returns at c0+1 sample point.
   task automatic issue(input logic [1:0] op, input logic [4:0] a, input logic [4:0] b,
                        input logic [4:0] d, input logic [5:0] vl);
      cmd_op    = op;
      cmd_src_a = a;
      cmd_src_b = b;
      cmd_dst   = d;
      cmd_vl    = vl;
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset_n = 1'b0;
      tick();
      tick();
      checks++;
      if ({cmd_ready, busy, done, rd_en, wr_en} !== 5'b0) begin
         failures++;
         $display("FAIL reset_flags got=%b exp=00000", {cmd_ready, busy, done, rd_en, wr_en});
      end
      checks++;
      if ({rd_addr_a, rd_addr_b, wr_addr} !== 15'h0) begin
         failures++;
         $display("FAIL reset_addrs got=%h exp=0", {rd_addr_a, rd_addr_b, wr_addr});
      end
      checks++;
      if ({wr_data, bw_operand_a, bw_operand_b, bw_control} !== 98'h0) begin
         failures++;
         $display("FAIL reset_data got=%h/%h/%h/%b exp=0", wr_data, bw_operand_a, bw_operand_b, bw_control);
      end
      reset_n = 1'b1;
      tick();
      checks++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_release got=ready%b busy%b exp=ready1 busy0", cmd_ready, busy);
      end
   endtask

   task automatic test_and();
      logic [31:0] exp_d [4];
      exp_d = '{32'h0F0F_0000, 32'h0F0F_0001, 32'h0F0F_0002, 32'h0F0F_0003};
      for (int k = 0; k < 4; k++) begin
         load(5'(k), 32'hFFFF_0000 + 32'(k));
         load(5'(8 + k), 32'h0F0F_0F0F);
      end
      issue(2'b00, 5'd0, 5'd8, 5'd16, 6'd4);
      for (int n = 1; n <= 7; n++) begin
         checks++;
         if (rd_en !== (n <= 4)) begin
            failures++;
            $display("FAIL and_rd_en n=%0d got=%b exp=%b", n, rd_en, n <= 4);
         end
         if (n <= 4) begin
            checks++;
            if (rd_addr_a !== 5'(n - 1) || rd_addr_b !== 5'(8 + n - 1)) begin
               failures++;
               $display("FAIL and_rd_addr n=%0d got=%0d/%0d exp=%0d/%0d", n, rd_addr_a, rd_addr_b, n - 1, 8 + n - 1);
            end
         end
         if (n >= 2 && n <= 5) begin
            checks++;
            if (bw_operand_a !== 32'hFFFF_0000 + 32'(n - 2) || bw_operand_b !== 32'h0F0F_0F0F || bw_control !== 2'b00) begin
               failures++;
               $display("FAIL and_operands n=%0d got=%h/%h/%b exp=%h/0f0f0f0f/00", n, bw_operand_a, bw_operand_b,
                        bw_control, 32'hFFFF_0000 + 32'(n - 2));
            end
         end
         checks++;
         if (wr_en !== (n >= 3 && n <= 6)) begin
            failures++;
            $display("FAIL and_wr_en n=%0d got=%b exp=%b", n, wr_en, n >= 3 && n <= 6);
         end
         if (n >= 3 && n <= 6) begin
            checks++;
            if (wr_addr !== 5'(16 + n - 3) || wr_data !== exp_d[n-3]) begin
               failures++;
               $display("FAIL and_write n=%0d got=%0d:%h exp=%0d:%h", n, wr_addr, wr_data, 16 + n - 3, exp_d[n-3]);
            end
         end
         checks++;
         if (done !== (n == 6) || cmd_ready !== (n == 7) || busy !== (n <= 6)) begin
            failures++;
            $display("FAIL and_ctrl n=%0d got=done%b ready%b busy%b exp=done%b ready%b busy%b", n, done, cmd_ready,
                     busy, n == 6, n == 7, n <= 6);
         end
         tick();
      end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (mem[16+k] !== exp_d[k]) begin
            failures++;
            $display("FAIL and_mem k=%0d got=%h exp=%h", k, mem[16+k], exp_d[k]);
         end
      end
   endtask

   task automatic test_xor_inplace();
      int wr_cnt;
      int done_cnt;
      wr_cnt   = 0;
      done_cnt = 0;
      for (int k = 0; k < 8; k++) begin
         load(5'(4 + k), 32'h1234_5600 + 32'(k));
         load(5'(20 + k), 32'hAAAA_AAAA);
      end
      issue(2'b10, 5'd4, 5'd20, 5'd4, 6'd8);
      for (int n = 1; n <= 11; n++) begin
         if (wr_en === 1'b1) begin
            wr_cnt++;
            checks++;
            if (wr_addr !== 5'(4 + n - 3) || wr_data !== ((32'h1234_5600 + 32'(n - 3)) ^ 32'hAAAA_AAAA)) begin
               failures++;
               $display("FAIL xor_write n=%0d got=%0d:%h exp=%0d:%h", n, wr_addr, wr_data, 4 + n - 3,
                        (32'h1234_5600 + 32'(n - 3)) ^ 32'hAAAA_AAAA);
            end
         end
         if (done === 1'b1) begin
            done_cnt++;
            checks++;
            if (n != 10) begin
               failures++;
               $display("FAIL xor_done_cycle got=c0+%0d exp=c0+10", n);
            end
         end
         tick();
      end
      checks++;
      if (wr_cnt != 8 || done_cnt != 1) begin
         failures++;
         $display("FAIL xor_counts got=wr%0d done%0d exp=wr8 done1", wr_cnt, done_cnt);
      end
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (mem[4+k] !== ((32'h1234_5600 + 32'(k)) ^ 32'hAAAA_AAAA)) begin
            failures++;
            $display("FAIL xor_mem k=%0d got=%h exp=%h", k, mem[4+k], (32'h1234_5600 + 32'(k)) ^ 32'hAAAA_AAAA);
         end
      end
   endtask

   task automatic test_wrap();
      logic [4:0]  exp_ra [3];
      logic [4:0]  exp_rb [3];
      logic [4:0]  exp_wa [3];
      logic [31:0] exp_wd [3];
      exp_ra = '{5'd30, 5'd31, 5'd0};
      exp_rb = '{5'd0, 5'd1, 5'd2};
      exp_wa = '{5'd31, 5'd0, 5'd1};
      exp_wd = '{32'h0000_00FF, 32'h1000_0F00, 32'h0200_000F};
      load(5'd30, 32'h0000_00F0);
      load(5'd31, 32'h0000_0F00);
      load(5'd0,  32'h0000_000F);
      load(5'd1,  32'h1000_0000);
      load(5'd2,  32'h0200_0000);
      issue(2'b01, 5'd30, 5'd0, 5'd31, 6'd3);
      for (int n = 1; n <= 6; n++) begin
         checks++;
         if (rd_en !== (n <= 3) || wr_en !== (n >= 3 && n <= 5)) begin
            failures++;
            $display("FAIL wrap_strobes n=%0d got=rd%b wr%b exp=rd%b wr%b", n, rd_en, wr_en, n <= 3, n >= 3 && n <= 5);
         end
         if (n <= 3) begin
            checks++;
            if (rd_addr_a !== exp_ra[n-1] || rd_addr_b !== exp_rb[n-1]) begin
               failures++;
               $display("FAIL wrap_rd_addr n=%0d got=%0d/%0d exp=%0d/%0d", n, rd_addr_a, rd_addr_b, exp_ra[n-1],
                        exp_rb[n-1]);
            end
         end
         if (n >= 3 && n <= 5) begin
            checks++;
            if (wr_addr !== exp_wa[n-3] || wr_data !== exp_wd[n-3]) begin
               failures++;
               $display("FAIL wrap_write n=%0d got=%0d:%h exp=%0d:%h", n, wr_addr, wr_data, exp_wa[n-3], exp_wd[n-3]);
            end
         end
         checks++;
         if (done !== (n == 5) || cmd_ready !== (n == 6)) begin
            failures++;
            $display("FAIL wrap_ctrl n=%0d got=done%b ready%b exp=done%b ready%b", n, done, cmd_ready, n == 5, n == 6);
         end
         tick();
      end
   endtask

   task automatic test_vl0_op11();
      issue(2'b00, 5'd3, 5'd7, 5'd9, 6'd0);
      for (int n = 1; n <= 2; n++) begin
         checks++;
         if (rd_en !== 1'b0 || wr_en !== 1'b0 || done !== (n == 1) || busy !== (n == 1) || cmd_ready !== (n == 2)) begin
            failures++;
            $display("FAIL vl0 n=%0d got=rd%b wr%b done%b busy%b ready%b exp=rd0 wr0 done%b busy%b ready%b", n, rd_en,
                     wr_en, done, busy, cmd_ready, n == 1, n == 1, n == 2);
         end
         tick();
      end
      load(5'd24, 32'hDEAD_BEEF);
      load(5'd25, 32'hDEAD_BEEF);
      load(5'd0,  32'h1357_9BDF);
      load(5'd1,  32'hFFFF_FFFF);
      load(5'd8,  32'hFFFF_FFFF);
      load(5'd9,  32'h2468_ACE0);
      issue(2'b11, 5'd0, 5'd8, 5'd24, 6'd2);
      for (int n = 1; n <= 5; n++) begin
         if (n == 2 || n == 3) begin
            checks++;
            if (bw_control !== 2'b11) begin
               failures++;
               $display("FAIL op11_control n=%0d got=%b exp=11", n, bw_control);
            end
         end
         checks++;
         if (wr_en !== (n == 3 || n == 4) || done !== (n == 4)) begin
            failures++;
            $display("FAIL op11_ctrl n=%0d got=wr%b done%b exp=wr%b done%b", n, wr_en, done, n == 3 || n == 4, n == 4);
         end
         if (n == 3 || n == 4) begin
            checks++;
            if (wr_addr !== 5'(24 + n - 3) || wr_data !== 32'h0) begin
               failures++;
               $display("FAIL op11_write n=%0d got=%0d:%h exp=%0d:00000000", n, wr_addr, wr_data, 24 + n - 3);
            end
         end
         tick();
      end
      checks++;
      if (mem[24] !== 32'h0 || mem[25] !== 32'h0) begin
         failures++;
         $display("FAIL op11_mem got=%h/%h exp=0/0", mem[24], mem[25]);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp1 [2];
      exp1 = '{32'h3300_1111, 32'h4400_2222};
      load(5'd0,  32'h0000_1111);
      load(5'd1,  32'h0000_2222);
      load(5'd8,  32'h3300_0000);
      load(5'd9,  32'h4400_0000);
      load(5'd16, 32'hF0F0_F0F0);
      load(5'd17, 32'hFF00_FF00);
      cmd_op    = 2'b01;
      cmd_src_a = 5'd0;
      cmd_src_b = 5'd8;
      cmd_dst   = 5'd12;
      cmd_vl    = 6'd2;
      cmd_valid = 1'b1;
      tick();
      // second command offered and held while the first is in flight
      cmd_op    = 2'b00;
      cmd_src_a = 5'd16;
      cmd_src_b = 5'd17;
      cmd_dst   = 5'd28;
      cmd_vl    = 6'd1;
      for (int n = 1; n <= 5; n++) begin
         checks++;
         if (rd_en !== (n <= 2) || cmd_ready !== (n == 5) || done !== (n == 4)) begin
            failures++;
            $display("FAIL b2b_first n=%0d got=rd%b ready%b done%b exp=rd%b ready%b done%b", n, rd_en, cmd_ready, done,
                     n <= 2, n == 5, n == 4);
         end
         if (n <= 2) begin
            checks++;
            if (rd_addr_a !== 5'(n - 1)) begin
               failures++;
               $display("FAIL b2b_first_addr n=%0d got=%0d exp=%0d", n, rd_addr_a, n - 1);
            end
         end
         if (n == 3 || n == 4) begin
            checks++;
            if (wr_en !== 1'b1 || wr_addr !== 5'(12 + n - 3) || wr_data !== exp1[n-3]) begin
               failures++;
               $display("FAIL b2b_first_write n=%0d got=%b %0d:%h exp=1 %0d:%h", n, wr_en, wr_addr, wr_data,
                        12 + n - 3, exp1[n-3]);
            end
         end
         tick();
      end
      // the edge ending c0+5 was the second handshake; now at c1+1
      cmd_valid = 1'b0;
      for (int n = 1; n <= 4; n++) begin
         checks++;
         if (rd_en !== (n == 1) || wr_en !== (n == 3) || done !== (n == 3) || cmd_ready !== (n == 4)) begin
            failures++;
            $display("FAIL b2b_second n=%0d got=rd%b wr%b done%b ready%b exp=rd%b wr%b done%b ready%b", n, rd_en,
                     wr_en, done, cmd_ready, n == 1, n == 3, n == 3, n == 4);
         end
         if (n == 1) begin
            checks++;
            if (rd_addr_a !== 5'd16 || rd_addr_b !== 5'd17) begin
               failures++;
               $display("FAIL b2b_second_addr got=%0d/%0d exp=16/17", rd_addr_a, rd_addr_b);
            end
         end
         if (n == 3) begin
            checks++;
            if (wr_addr !== 5'd28 || wr_data !== 32'hF000_F000) begin
               failures++;
               $display("FAIL b2b_second_write got=%0d:%h exp=28:f000f000", wr_addr, wr_data);
            end
         end
         tick();
      end
      checks++;
      if (mem[12] !== exp1[0] || mem[13] !== exp1[1] || mem[28] !== 32'hF000_F000) begin
         failures++;
         $display("FAIL b2b_mem got=%h/%h/%h exp=%h/%h/f000f000", mem[12], mem[13], mem[28], exp1[0], exp1[1]);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] exp_d [2];
      exp_d = '{32'h0000_00FF, 32'h0F0F_0000};
      issue(2'b00, 5'd0, 5'd8, 5'd20, 6'd8);
      tick();
      tick();
      reset_n = 1'b0;             // low during cycle c0+3
      for (int n = 4; n <= 5; n++) begin
         tick();
         checks++;
         if ({wr_en, rd_en, busy, done, cmd_ready} !== 5'b0) begin
            failures++;
            $display("FAIL midreset n=%0d got=wr%b rd%b busy%b done%b ready%b exp=all0", n, wr_en, rd_en, busy, done,
                     cmd_ready);
         end
      end
      reset_n = 1'b1;
      tick();
      checks++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0 || wr_en !== 1'b0 || rd_en !== 1'b0) begin
         failures++;
         $display("FAIL midreset_release got=ready%b busy%b wr%b rd%b exp=ready1 busy0 wr0 rd0", cmd_ready, busy,
                  wr_en, rd_en);
      end
      load(5'd0, 32'h0000_FFFF);
      load(5'd1, 32'hFFFF_0000);
      load(5'd8, 32'h00FF_00FF);
      load(5'd9, 32'h0F0F_0F0F);
      issue(2'b00, 5'd0, 5'd8, 5'd24, 6'd2);
      for (int n = 1; n <= 5; n++) begin
         checks++;
         if (wr_en !== (n == 3 || n == 4) || done !== (n == 4) || cmd_ready !== (n == 5)) begin
            failures++;
            $display("FAIL fresh_ctrl n=%0d got=wr%b done%b ready%b exp=wr%b done%b ready%b", n, wr_en, done,
                     cmd_ready, n == 3 || n == 4, n == 4, n == 5);
         end
         if (n == 3 || n == 4) begin
            checks++;
            if (wr_addr !== 5'(24 + n - 3) || wr_data !== exp_d[n-3]) begin
               failures++;
               $display("FAIL fresh_write n=%0d got=%0d:%h exp=%0d:%h", n, wr_addr, wr_data, 24 + n - 3, exp_d[n-3]);
            end
         end
         tick();
      end
      checks++;
      if (mem[24] !== exp_d[0] || mem[25] !== exp_d[1]) begin
         failures++;
         $display("FAIL fresh_mem got=%h/%h exp=%h/%h", mem[24], mem[25], exp_d[0], exp_d[1]);
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      checks    = 0;
      failures  = 0;
      reset_n   = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = 2'b00;
      cmd_src_a = '0;
      cmd_src_b = '0;
      cmd_dst   = '0;
      cmd_vl    = '0;
      pl_en     = 1'b0;
      pl_addr   = '0;
      pl_data   = '0;
      test_reset();
      test_and();
      test_xor_inplace();
      test_wrap();
      test_vl0_op11();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

endmodule
